// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle control path: FSM state encoding
// and the RV32 major opcodes the sequencer accepts.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, guards memory waits with a timeout, counts retirements.
//
// state  | meaning
// FETCH  | request instruction word at PC; on mem_ready load IR, PC+4
// DECODE | check opcode legality
// EXEC   | ALU step; branches and jumps update PC here
// MEM    | data access at ALU result; load -> WB, store retires
// WB     | register file write, instruction retires
// HALT   | illegal opcode or memory timeout; exit only by reset
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        reg_write_en,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_ifetch,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src_target,
    output logic        rf_write,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] retired
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        run_q;
    logic [3:0]  wait_q;
    logic [31:0] retired_q;
    logic        retire;
    logic        timeout;

    assign timeout = (wait_q == WAIT_LAST);

    // run_q keeps mem_req low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            run_q     <= 1'b0;
            wait_q    <= 4'd0;
            retired_q <= 32'd0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            if (state_d != state_q)
                wait_q <= 4'd0;
            else if (mem_req)
                wait_q <= wait_q + 4'd1;
            if (retire)
                retired_q <= retired_q + 32'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_ifetch    = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src_target = 1'b0;
        rf_write      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    mem_req    = 1'b1;
                    mem_ifetch = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else if (timeout) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: state_d = ST_EXEC;
                    default:                                          state_d = ST_HALT;
                endcase
            end
            ST_EXEC: begin
                if (MemRead || MemWrite) begin
                    state_d = ST_MEM;
                end else if (Branch) begin
                    pc_write      = branch_taken;
                    pc_src_target = branch_taken;
                    retire        = 1'b1;
                    state_d       = ST_FETCH;
                end else if (Jump) begin
                    pc_write      = 1'b1;
                    pc_src_target = 1'b1;
                    state_d       = ST_WB;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = MemWrite;
                // mem_ready wins over a timeout landing on the same cycle
                if (mem_ready) begin
                    if (MemWrite) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                rf_write = reg_write_en;
                retire   = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    assign state   = state_q;
    assign halted  = (state_q == ST_HALT);
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: expected per-cycle state, strobes,
// halted and retired values are queued as each step is driven, then popped and compared.
module tb_multicycle_sequencer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        reg_write_en = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic        Branch = 1'b0, Jump = 1'b0, branch_taken = 1'b0, mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_ifetch, ir_write, pc_write, pc_src_target, rf_write;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] retired;

    multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .reg_write_en(reg_write_en),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_ifetch(mem_ifetch), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src_target(pc_src_target), .rf_write(rf_write),
        .state(state), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    // strobe order: {mem_req, mem_we, mem_ifetch, ir_write, pc_write, pc_src_target, rf_write}
    localparam logic [6:0] S_NONE  = 7'b0000000;
    localparam logic [6:0] S_FRDY  = 7'b1011100;
    localparam logic [6:0] S_FWAIT = 7'b1010000;
    localparam logic [6:0] S_MRD   = 7'b1000000;
    localparam logic [6:0] S_MWR   = 7'b1100000;
    localparam logic [6:0] S_PCT   = 7'b0000110;
    localparam logic [6:0] S_RF    = 7'b0000001;
    // ctl order: {reg_write_en, MemRead, MemWrite, Branch, Jump}
    localparam logic [4:0] C_ADD = 5'b10000;
    localparam logic [4:0] C_LW  = 5'b11000;
    localparam logic [4:0] C_SW  = 5'b00100;
    localparam logic [4:0] C_BR  = 5'b00010;
    localparam logic [4:0] C_JAL = 5'b10001;
    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, H = 3'd7;

    logic [42:0] sb_q[$];
    logic [31:0] ret_m = 32'd0;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic expect_out(input logic [2:0] est, input logic [6:0] estb);
        sb_q.push_back({est, estb, (est == 3'd7), ret_m});
    endtask

    task automatic check(input string tag);
        logic [42:0] e, o;
        e = sb_q.pop_front();
        o = {state, mem_req, mem_we, mem_ifetch, ir_write, pc_write, pc_src_target,
             rf_write, halted, retired};
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: state=%0d strobes=%b halted=%b retired=%0d, expected state=%0d strobes=%b halted=%b retired=%0d",
                   tag, o[42:40], o[39:33], o[32], o[31:0], e[42:40], e[39:33], e[32], e[31:0]);
        end
    endtask

    task automatic step(input string tag, input logic [6:0] op, input logic [4:0] ctl,
                        input logic bt, input logic rdy, input logic [2:0] est,
                        input logic [6:0] estb, input logic retires);
        @(negedge clk);
        opcode = op;
        {reg_write_en, MemRead, MemWrite, Branch, Jump} = ctl;
        branch_taken = bt;
        mem_ready = rdy;
        expect_out(est, estb);
        #1;
        check(tag);
        if (retires) ret_m = ret_m + 32'd1;
    endtask

    task automatic reset_now(input string tag);
        rst_n = 1'b0;
        ret_m = 32'd0;
        expect_out(F, S_NONE);
        #1;
        check(tag);
        @(negedge clk);
        rst_n = 1'b1;
        {reg_write_en, MemRead, MemWrite, Branch, Jump} = 5'b0;
        branch_taken = 1'b0;
        mem_ready = 1'b0;
        expect_out(F, S_NONE);
        #1;
        check({tag, "_release"});
    endtask

    initial begin
        #3;
        reset_now("reset");

        step("add_fetch",  OP_R, C_ADD, 0, 1, F, S_FRDY, 0);
        step("add_decode", OP_R, C_ADD, 0, 1, D, S_NONE, 0);
        step("add_exec",   OP_R, C_ADD, 0, 1, E, S_NONE, 0);
        step("add_wb",     OP_R, C_ADD, 0, 1, W, S_RF,   1);

        step("lw_fetch",  OP_LOAD, C_LW, 0, 1, F, S_FRDY, 0);
        step("lw_decode", OP_LOAD, C_LW, 0, 0, D, S_NONE, 0);
        step("lw_exec",   OP_LOAD, C_LW, 0, 0, E, S_NONE, 0);
        for (int i = 0; i < 3; i++)
            step("lw_mem_wait", OP_LOAD, C_LW, 0, 0, M, S_MRD, 0);
        step("lw_mem_rdy", OP_LOAD, C_LW, 0, 1, M, S_MRD, 0);
        step("lw_wb",      OP_LOAD, C_LW, 0, 0, W, S_RF,  1);

        step("beqt_fetch",  OP_BRANCH, C_BR, 1, 1, F, S_FRDY, 0);
        step("beqt_decode", OP_BRANCH, C_BR, 1, 0, D, S_NONE, 0);
        step("beqt_exec",   OP_BRANCH, C_BR, 1, 0, E, S_PCT,  1);

        step("beqn_fetch",  OP_BRANCH, C_BR, 0, 1, F, S_FRDY, 0);
        step("beqn_decode", OP_BRANCH, C_BR, 0, 0, D, S_NONE, 0);
        step("beqn_exec",   OP_BRANCH, C_BR, 0, 0, E, S_NONE, 1);

        step("jal_fetch",  OP_JAL, C_JAL, 0, 1, F, S_FRDY, 0);
        step("jal_decode", OP_JAL, C_JAL, 0, 0, D, S_NONE, 0);
        step("jal_exec",   OP_JAL, C_JAL, 0, 0, E, S_PCT,  0);
        step("jal_wb",     OP_JAL, C_JAL, 0, 0, W, S_RF,   1);

        step("sw_fetch",  OP_STORE, C_SW, 0, 1, F, S_FRDY, 0);
        step("sw_decode", OP_STORE, C_SW, 0, 0, D, S_NONE, 0);
        step("sw_exec",   OP_STORE, C_SW, 0, 0, E, S_NONE, 0);
        step("sw_mem",    OP_STORE, C_SW, 0, 1, M, S_MWR,  1);

        step("sw2_fetch",  OP_STORE, C_SW, 0, 1, F, S_FRDY, 0);
        step("sw2_decode", OP_STORE, C_SW, 0, 0, D, S_NONE, 0);
        step("sw2_exec",   OP_STORE, C_SW, 0, 0, E, S_NONE, 0);
        step("sw2_mem",    OP_STORE, C_SW, 0, 0, M, S_MWR,  0);
        #2;
        reset_now("sw2_mid_reset");

        for (int i = 0; i < 14; i++)
            step("fetch_wait", OP_R, C_ADD, 0, 0, F, S_FWAIT, 0);
        step("fetch_rdy_15th", 7'b1110011, 5'b0, 0, 1, F, S_FRDY, 0);
        step("illegal_decode", 7'b1110011, 5'b0, 0, 1, D, S_NONE, 0);
        for (int i = 0; i < 20; i++)
            step("halt_hold", 7'b1110011, 5'b0, 0, i[0], H, S_NONE, 0);

        reset_now("reset_after_halt");
        for (int i = 0; i < 15; i++)
            step("timeout_wait", OP_R, C_ADD, 0, 0, F, S_FWAIT, 0);
        step("timeout_halt",  OP_R, C_ADD, 0, 1, H, S_NONE, 0);
        step("timeout_stays", OP_R, C_ADD, 0, 1, H, S_NONE, 0);

        reset_now("final_reset");
        step("resume_fetch",  OP_I, C_ADD, 0, 1, F, S_FRDY, 0);
        step("resume_decode", OP_I, C_ADD, 0, 0, D, S_NONE, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum cycles to wait for mem_ready before aborting to HALT.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 7 bits: opcode field of the instruction register.
REQ-005 SHALL have ports reg_write_en, MemRead, MemWrite, Branch and Jump, input, 1 bit each: decoded control signals for the current instruction.
REQ-006 SHALL have port branch_taken, input, 1 bit: branch comparison result, valid in EXEC.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory completion strobe for the current request.
REQ-008 SHALL have port mem_req, output, 1 bit: memory request, level held until mem_ready.
REQ-009 SHALL have port mem_we, output, 1 bit: write qualifier for mem_req.
REQ-010 SHALL have port mem_ifetch, output, 1 bit: memory address source is PC (1) or the ALU result (0).
REQ-011 SHALL have ports ir_write, pc_write, pc_src_target and rf_write, output, 1 bit each: single-cycle datapath strobes.
REQ-012 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-013 SHALL have port halted, output, 1 bit: sticky error indicator.
REQ-014 SHALL have port retired, output, 32 bits: count of completed instructions.

Function
REQ-015 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-016 SHALL behave as follows in FETCH: mem_req=1, mem_ifetch=1, mem_we=0. On mem_ready: ir_write=1 and pc_write=1 (PC+4) in that cycle, then go to DECODE.
REQ-017 SHALL go from DECODE to EXEC when opcode is in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111}, and to HALT otherwise.
REQ-018 SHALL leave EXEC as follows:
- MemRead or MemWrite set: go to MEM.
- Branch set: go to FETCH, with pc_write=1 and pc_src_target=1 in EXEC only if branch_taken.
- Jump set: pc_write=1 and pc_src_target=1, then go to WB.
- Otherwise: go to WB.
REQ-019 SHALL behave as follows in MEM: mem_req=1, mem_ifetch=0, mem_we=MemWrite. On mem_ready, a load goes to WB and a store goes to FETCH.
REQ-020 SHALL assert rf_write=reg_write_en for exactly one cycle in WB, then go to FETCH.
REQ-021 SHALL increment retired by 1, wrapping at 2^32-1 to 0, in the cycle an instruction leaves its final state: WB, store MEM, or EXEC for a branch.
REQ-022 SHALL count cycles with mem_req high in FETCH or MEM using a 4-bit wait counter, cleared on each state entry; when the count reaches MEM_TIMEOUT without mem_ready, the FSM SHALL go to HALT.
REQ-023 SHALL give mem_ready priority over timeout when both occur in the same cycle.
REQ-024 SHALL ignore mem_ready in DECODE, EXEC and WB.
REQ-025 SHALL, in HALT, keep every strobe at 0 and halted=1, and leave HALT only through reset.
REQ-026 SHALL drive mem_req, mem_we, mem_ifetch, ir_write, pc_write, pc_src_target and rf_write as Moore/Mealy decodes of the state register and inputs, with no extra register delay.

Reset
REQ-027 SHALL, while rst_n=0, immediately set state=FETCH, retired=0, wait counter=0 and halted=0.
REQ-028 SHALL hold all strobes at 0 during reset, with mem_req rising only after the first clk edge following reset release.
REQ-029 SHALL, on reset asserted mid-transaction (any state), abandon the outstanding request; a mem_ready arriving after release SHALL be treated as belonging to the new FETCH.

Structure
REQ-030 SHALL take the state enum and the opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL) from a shared package seq_pkg, which is also imported by the decoder.
REQ-031 SHALL be a single module with no sub-module; the wait counter and the retired counter are inline.

Verification
REQ-032 SHALL cover: add (opcode 0110011, reg_write_en=1) with mem_ready after 0 waits -> state sequence 0,1,2,4,0; rf_write high one cycle in WB; retired 0->1.
REQ-033 SHALL cover: lw with mem_ready after 3 waits in MEM -> mem_req high for 4 MEM cycles, mem_ifetch=0, then WB with rf_write=1.
REQ-034 SHALL cover: beq with branch_taken=1 -> pc_write=1 and pc_src_target=1 in EXEC, next state FETCH; with branch_taken=0 -> pc_write=0 in EXEC; retired increments in both cases.
REQ-035 SHALL cover: opcode 1110011 -> DECODE then HALT, halted=1, strobes stay 0 for 20 cycles despite mem_ready toggling.
REQ-036 SHALL cover: mem_ready never asserted in FETCH -> HALT after exactly 15 request cycles; mem_ready asserted on the 15th cycle -> no halt, proceeds to DECODE.
REQ-037 SHALL cover: rst_n pulsed low in MEM of a sw -> immediate state=0, mem_req=0, retired=0; after release the normal fetch resumes.
